conteo_vecinos: RTL
===================

CONTEO_VECINOS -- requirements
Module: conteo_vecinos

Interface
REQ-001 SHALL have parameter DIM, default 8, board side length in cells; 8 is the only legal value.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port matriz  input  8x[7:0]  mine map from selecMinas; matriz[f][c]=1 means mine at row f, column c.
REQ-005 SHALL have port inicio  input  1  scan request, sampled on clk.
REQ-006 SHALL have port ocupado  output  1  high while a scan is in progress.
REQ-007 SHALL have port listo  output  1  one-cycle pulse on scan completion.
REQ-008 SHALL have ports rd_fila and rd_col  input  3 each  read address.
REQ-009 SHALL have port rd_conteo  output  4  neighbour count at the read address, range 0..8.
REQ-010 SHALL have port rd_mina  output  1  snapshot mine bit at the read address.
REQ-011 SHALL have port total_minas  output  7  mine total of the last scan, range 0..64.

Function
REQ-012 SHALL implement FSM states IDLE, BARRIDO and FIN.
REQ-013 IDLE: inicio=1 at edge T SHALL copy matriz into an internal snapshot, clear the cell index to 0 and total_minas to 0, and enter BARRIDO.
REQ-014 BARRIDO: each edge SHALL process one cell, idx 0..63, fila=idx[5:3], col=idx[2:0], writing its count into a 64x4 count memory.
REQ-015 BARRIDO SHALL add the snapshot bit of the processed cell to total_minas on each edge.
REQ-016 Count SHALL be the sum of the snapshot bits of the 8 surrounding cells; the cell's own bit SHALL NOT be included.
REQ-017 After the write of idx 63 at edge T+64, the FSM SHALL enter FIN.
REQ-018 FIN SHALL drive listo=1 for exactly one cycle, then return to IDLE at edge T+65.
REQ-019 ocupado SHALL be 1 in BARRIDO and FIN and 0 in IDLE.
REQ-020 inicio SHALL be ignored outside IDLE; a new scan SHALL start only from IDLE.
REQ-021 The result SHALL depend only on the snapshot; changes on matriz during a scan SHALL have no effect.
REQ-022 Reads SHALL be registered with 1-cycle latency: rd_conteo and rd_mina SHALL reflect the address presented at the previous edge.
REQ-023 A read during BARRIDO SHALL return the memory content at that moment (new value if already written, otherwise the previous scan's value).
REQ-024 total_minas SHALL be final when listo=1 and SHALL hold until the next inicio is accepted.
REQ-025 Count arithmetic SHALL be 4 bits wide, with no saturation needed because the maximum is 8.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, ocupado=0, listo=0, total_minas=0, rd_conteo=0, rd_mina=0.
REQ-027 rst_n=0 SHALL immediately clear the snapshot, the count memory and the index to 0.
REQ-028 Reset mid-scan SHALL abort the scan with no listo pulse; memory reads SHALL return 0 afterwards.
REQ-029 The first inicio after rst_n rises SHALL be accepted normally.

Configuration
REQ-030 Macro VECINOS_TOROIDAL_EN defined: neighbour coordinates SHALL wrap modulo 8, so every cell has 8 neighbours.
REQ-031 Macro VECINOS_TOROIDAL_EN undefined: neighbours outside 0..7 SHALL contribute 0.

Verification
REQ-032 All-zero matriz, inicio at T -> listo high only in cycle T+64..T+65; all 64 rd_conteo=0; total_minas=0.
REQ-033 Single mine at (3,4) -> the 8 cells (2..4,3..5) except (3,4) read 1; (3,4) reads 0 with rd_mina=1; all other cells read 0; total_minas=1.
REQ-034 Single mine at (0,0), macro off -> (0,1),(1,0),(1,1) read 1; (7,7) reads 0.
REQ-035 Single mine at (0,0), macro on -> (0,1),(1,0),(1,1),(7,7),(0,7),(7,0),(1,7),(7,1) read 1.
REQ-036 All-ones matriz, macro off -> corners read 3, non-corner edges read 5, interior reads 8, total_minas=64; macro on -> all cells read 8.
REQ-037 Start scan with a mine at (3,4); at cycle 10 set matriz all-ones and pulse inicio; at cycle 30 pulse rst_n low -> result tracks only the snapshot until the reset; inicio ignored; after reset ocupado=0, listo never pulses, all reads return 0.

Source files
------------

// File: rtl/conteo_vecinos.sv
// ---------------------------------------------------------------------------
// conteo_vecinos
//   Takes a snapshot of an 8x8 mine map and scans it one cell per clock,
//   storing how many of each cell's 8 surrounding cells hold a mine in a
//   64x4 count memory. The total number of mines is accumulated during the
//   scan. Results can be read back through a registered read port.
//
//   Optional feature macro: VECINOS_TOROIDAL_EN
//     defined   -> neighbour coordinates wrap around the board (torus)
//     undefined -> neighbours outside the board count as empty
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   matriz       mine map, matriz[f][c] = 1 means mine at row f, column c
//   inicio       scan request, accepted only while idle
//   ocupado      high while a scan is in progress (BARRIDO or FIN)
//   listo        one-cycle pulse when the scan completes
//   rd_fila/col  read address (row / column)
//   rd_conteo    neighbour count at the read address (1-cycle latency)
//   rd_mina      snapshot mine bit at the read address (1-cycle latency)
//   total_minas  mine total of the last scan
// ---------------------------------------------------------------------------
module conteo_vecinos #(
    parameter int DIM = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIM-1:0][DIM-1:0]   matriz,
    input  logic                      inicio,
    output logic                      ocupado,
    output logic                      listo,
    input  logic [2:0]                rd_fila,
    input  logic [2:0]                rd_col,
    output logic [3:0]                rd_conteo,
    output logic                      rd_mina,
    output logic [6:0]                total_minas
);

    localparam int CELDAS = DIM * DIM;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BARRIDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t                  r_estado;
    estado_t                  w_estado_sig;

    logic [DIM-1:0][DIM-1:0]  r_snap;
    logic [5:0]               r_idx;
    logic [6:0]               r_total;
    logic [3:0]               r_mem [CELDAS];
    logic [3:0]               r_rd_conteo;
    logic                     r_rd_mina;

    logic [2:0]               w_fila;
    logic [2:0]               w_col;
    logic [3:0]               w_conteo;
    logic                     w_arranque;

    // Sum of the 8 surrounding snapshot bits. The 3-bit cast of the
    // neighbour coordinate maps -1 to 7 and 8 to 0, which is exactly the
    // wrap-around needed for the toroidal board.
    function automatic logic [3:0] contar_vecinos(
        input logic [DIM-1:0][DIM-1:0] snap,
        input logic [2:0]              fila,
        input logic [2:0]              col
    );
        logic [3:0] suma;
        int         nf;
        int         nc;
        suma = '0;
        for (int df = -1; df <= 1; df++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (df != 0 || dc != 0) begin
                    nf = int'(fila) + df;
                    nc = int'(col) + dc;
`ifdef VECINOS_TOROIDAL_EN
                    suma = suma + 4'(snap[3'(nf)][3'(nc)]);
`else
                    if (nf >= 0 && nf < DIM && nc >= 0 && nc < DIM) begin
                        suma = suma + 4'(snap[3'(nf)][3'(nc)]);
                    end
`endif
                end
            end
        end
        return suma;
    endfunction

    assign w_fila     = r_idx[5:3];
    assign w_col      = r_idx[2:0];
    assign w_conteo   = contar_vecinos(r_snap, w_fila, w_col);
    assign w_arranque = (r_estado == IDLE) && inicio;

    assign rd_conteo   = r_rd_conteo;
    assign rd_mina     = r_rd_mina;
    assign total_minas = r_total;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_estado_sig = r_estado;
        ocupado      = 1'b0;
        listo        = 1'b0;
        case (r_estado)
            IDLE: begin
                if (inicio) begin
                    w_estado_sig = BARRIDO;
                end
            end
            BARRIDO: begin
                ocupado = 1'b1;
                if (r_idx == 6'd63) begin
                    w_estado_sig = FIN;
                end
            end
            FIN: begin
                ocupado      = 1'b1;
                listo        = 1'b1;
                w_estado_sig = IDLE;
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    // Snapshot, scan datapath, count memory and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap      <= '0;
            r_idx       <= '0;
            r_total     <= '0;
            r_rd_conteo <= '0;
            r_rd_mina   <= 1'b0;
            for (int i = 0; i < CELDAS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_arranque) begin
                r_snap  <= matriz;
                r_idx   <= '0;
                r_total <= '0;
            end else if (r_estado == BARRIDO) begin
                r_mem[r_idx] <= w_conteo;
                r_total      <= r_total + 7'(r_snap[w_fila][w_col]);
                r_idx        <= r_idx + 6'd1;
            end
            // Read sees the memory before this edge's write (old or new
            // value depending on scan progress).
            r_rd_conteo <= r_mem[{rd_fila, rd_col}];
            r_rd_mina   <= r_snap[rd_fila][rd_col];
        end
    end

endmodule
